// File: rtl/instr_encoder.sv
// instr_encoder: LEGv8 instruction encoder with a 2-entry write FIFO.
// Requests (op + fields) are range-checked and encoded into 32-bit words.
// Legal words are pushed with an auto-incrementing byte address.
// Ports:
//   CLK, Reset            clock, async active-high reset
//   start, base_addr      begin a program load at base_addr (IDLE only)
//   req_*                 encode request handshake and fields
//   mem_*                 instruction write handshake (FIFO head)
//   err, err_count        reject pulse and saturating reject count
//   word_count            words written since start (wrapping)
//   busy, done            load in progress / one-cycle completion pulse
module instr_encoder (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        start,
  input  logic [63:0] base_addr,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_rn,
  input  logic [4:0]  req_rm,
  input  logic [31:0] req_imm,
  input  logic [1:0]  req_hw,
  input  logic        req_last,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [63:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        err,
  output logic [7:0]  err_count,
  output logic [15:0] word_count,
  output logic        busy,
  output logic        done
);

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 2;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_ORR  = 4'd3;
  localparam logic [3:0] OP_ADDI = 4'd4;
  localparam logic [3:0] OP_SUBI = 4'd5;
  localparam logic [3:0] OP_MOVZ = 4'd6;
  localparam logic [3:0] OP_B    = 4'd7;
  localparam logic [3:0] OP_CBZ  = 4'd8;
  localparam logic [3:0] OP_LDUR = 4'd9;
  localparam logic [3:0] OP_STUR = 4'd10;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] word;
  } entry_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  entry_t             fifo0_q, fifo0_d;
  entry_t             fifo1_q, fifo1_d;
  logic               err_q, err_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic [7:0]         err_count_q, err_count_d;
  logic [15:0]        word_count_q, word_count_d;

  logic               legal;
  logic [WORD_W-1:0]  enc_word;
  logic signed [31:0] imm_s;
  logic               accept, push, pop;

  assign imm_s = req_imm;

  // Encoder and immediate range check
  always_comb begin
    enc_word = '0;
    legal    = 1'b1;
    case (req_op)
      OP_ADD:  enc_word = {11'b10001011000, req_rm, 6'b000000, req_rn, req_rd};
      OP_SUB:  enc_word = {11'b11001011000, req_rm, 6'b000000, req_rn, req_rd};
      OP_AND:  enc_word = {11'b10001010000, req_rm, 6'b000000, req_rn, req_rd};
      OP_ORR:  enc_word = {11'b10101010000, req_rm, 6'b000000, req_rn, req_rd};
      OP_ADDI, OP_SUBI: begin
        enc_word = {(req_op == OP_ADDI) ? 10'b1001000100 : 10'b1101000100,
                    req_imm[11:0], req_rn, req_rd};
        legal    = (imm_s >= 32'sd0) && (imm_s <= 32'sd4095);
      end
      OP_MOVZ: begin
        enc_word = {9'b110100101, req_hw, req_imm[15:0], req_rd};
        legal    = (imm_s >= 32'sd0) && (imm_s <= 32'sd65535);
      end
      OP_B: begin
        enc_word = {6'b000101, req_imm[25:0]};
        legal    = (imm_s >= -32'sd33554432) && (imm_s <= 32'sd33554431);
      end
      OP_CBZ: begin
        enc_word = {8'b10110100, req_imm[18:0], req_rd};
        legal    = (imm_s >= -32'sd262144) && (imm_s <= 32'sd262143);
      end
      OP_LDUR, OP_STUR: begin
        enc_word = {(req_op == OP_LDUR) ? 11'b11111000010 : 11'b11111000000,
                    req_imm[8:0], 2'b00, req_rn, req_rd};
        legal    = (imm_s >= -32'sd256) && (imm_s <= 32'sd255);
      end
      default: legal = 1'b0;
    endcase
  end

  // Ready depends only on registered state so it never loops back through req_valid
  assign req_ready = (state_q == RUN) && (count_q < CNT_W'(2));
  assign mem_valid = (count_q != '0);
  assign accept    = req_valid && req_ready;
  assign push      = accept && legal;
  assign pop       = mem_valid && mem_ready;

  // Next-state, FIFO and counters
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    count_d      = count_q;
    fifo0_d      = fifo0_q;
    fifo1_d      = fifo1_q;
    err_d        = 1'b0;
    done_d       = 1'b0;
    err_count_d  = err_count_q;
    word_count_d = word_count_q;

    // Shift FIFO: entry 0 is always the head
    if (pop) begin
      fifo0_d      = fifo1_q;
      word_count_d = word_count_q + 16'd1;
    end
    if (push) begin
      if ((count_q == '0) || ((count_q == CNT_W'(1)) && pop)) begin
        fifo0_d = {addr_q, enc_word};
      end else begin
        fifo1_d = {addr_q, enc_word};
      end
      addr_d = addr_q + ADDR_W'(4);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    if (accept && !legal) begin
      err_d = 1'b1;
      if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = RUN;
          addr_d       = base_addr;
          word_count_d = '0;
          err_count_d  = '0;
        end
      end
      RUN: begin
        if (accept && req_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (count_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      count_q      <= '0;
      fifo0_q      <= '0;
      fifo1_q      <= '0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      err_count_q  <= '0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      count_q      <= count_d;
      fifo0_q      <= fifo0_d;
      fifo1_q      <= fifo1_d;
      err_q        <= err_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      err_count_q  <= err_count_d;
      word_count_q <= word_count_d;
    end
  end

  assign mem_addr   = fifo0_q.addr;
  assign mem_wdata  = fifo0_q.word;
  assign err        = err_q;
  assign err_count  = err_count_q;
  assign word_count = word_count_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Testbench for instr_encoder: directed vectors plus randomized traffic
// checked every cycle against a queue-based behavioural model.
module tb_instr_encoder;

  logic        CLK, Reset, start;
  logic [63:0] base_addr;
  logic        req_valid, req_ready;
  logic [3:0]  req_op;
  logic [4:0]  req_rd, req_rn, req_rm;
  logic [31:0] req_imm;
  logic [1:0]  req_hw;
  logic        req_last;
  logic        mem_valid, mem_ready;
  logic [63:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        err;
  logic [7:0]  err_count;
  logic [15:0] word_count;
  logic        busy, done;

  instr_encoder dut (
    .CLK(CLK), .Reset(Reset), .start(start), .base_addr(base_addr),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rd(req_rd), .req_rn(req_rn), .req_rm(req_rm), .req_imm(req_imm),
    .req_hw(req_hw), .req_last(req_last), .mem_valid(mem_valid),
    .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .err(err), .err_count(err_count), .word_count(word_count),
    .busy(busy), .done(done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] a;
    logic [31:0] w;
  } ent_t;

  // Behavioural model: pending writes, load phase (0 idle, 1 run, 2 drain), counters
  ent_t        q[$];
  int          m_phase;
  logic [63:0] m_addr;
  int          m_wc;
  int          m_errc;
  bit          m_err, m_done;

  bit          s_acc, s_pop, s_done, s_busy;
  logic [63:0] s_pop_addr;
  logic [31:0] s_pop_word;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_legal(input int op, input longint imm);
    case (op)
      0, 1, 2, 3: return 1'b1;
      4, 5:       return (imm >= 0) && (imm <= 4095);
      6:          return (imm >= 0) && (imm <= 65535);
      7:          return (imm >= -(longint'(1) << 25)) && (imm <= (longint'(1) << 25) - 1);
      8:          return (imm >= -(longint'(1) << 18)) && (imm <= (longint'(1) << 18) - 1);
      9, 10:      return (imm >= -256) && (imm <= 255);
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_enc(input int op, input int rd, input int rn,
                                          input int rm, input longint imm, input int hw);
    logic [63:0] r, ui, f_rd, f_rn, f_rm;
    ui   = 64'(imm);
    f_rd = 64'(rd);
    f_rn = 64'(rn) << 5;
    f_rm = 64'(rm) << 16;
    case (op)
      0:  r = (64'h458 << 21) | f_rm | f_rn | f_rd;
      1:  r = (64'h658 << 21) | f_rm | f_rn | f_rd;
      2:  r = (64'h450 << 21) | f_rm | f_rn | f_rd;
      3:  r = (64'h550 << 21) | f_rm | f_rn | f_rd;
      4:  r = (64'h244 << 22) | ((ui & 64'hFFF) << 10) | f_rn | f_rd;
      5:  r = (64'h344 << 22) | ((ui & 64'hFFF) << 10) | f_rn | f_rd;
      6:  r = (64'h1A5 << 23) | (64'(hw) << 21) | ((ui & 64'hFFFF) << 5) | f_rd;
      7:  r = (64'd5 << 26) | (ui & 64'h3FF_FFFF);
      8:  r = (64'hB4 << 24) | ((ui & 64'h7FFFF) << 5) | f_rd;
      9:  r = (64'h7C2 << 21) | ((ui & 64'h1FF) << 12) | f_rn | f_rd;
      10: r = (64'h7C0 << 21) | ((ui & 64'h1FF) << 12) | f_rn | f_rd;
      default: r = '0;
    endcase
    return r[31:0];
  endfunction

  // Boundary-heavy immediate picker
  function automatic longint pick_imm(input int op);
    longint lo, hi;
    int sel;
    case (op)
      4, 5:  begin lo = 0;                      hi = 4095; end
      6:     begin lo = 0;                      hi = 65535; end
      7:     begin lo = -(longint'(1) << 25);   hi = (longint'(1) << 25) - 1; end
      8:     begin lo = -(longint'(1) << 18);   hi = (longint'(1) << 18) - 1; end
      9, 10: begin lo = -256;                   hi = 255; end
      default: return longint'($signed($urandom));
    endcase
    sel = int'($urandom % 6);
    case (sel)
      0: return lo;
      1: return hi;
      2: return lo - 1;
      3: return hi + 1;
      4: return lo + longint'($urandom % 32'(hi - lo + 1));
      default: return longint'($signed($urandom));
    endcase
  endfunction

  task automatic model_reset();
    q.delete();
    m_phase = 0;
    m_addr  = '0;
    m_wc    = 0;
    m_errc  = 0;
    m_err   = 1'b0;
    m_done  = 1'b0;
  endtask

  // One clock: check outputs mid-cycle, advance the model, return 1 time unit after the edge
  task automatic cycle();
    bit ev, er, pop, acc;
    longint simm;
    @(negedge CLK);
    ev = (q.size() != 0);
    er = (m_phase == 1) && (q.size() < 2);
    chk("mem_valid", 64'(mem_valid), 64'(ev));
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("err", 64'(err), 64'(m_err));
    chk("err_count", 64'(err_count), 64'(m_errc));
    chk("word_count", 64'(word_count), 64'(m_wc));
    chk("busy", 64'(busy), 64'(m_phase != 0));
    chk("done", 64'(done), 64'(m_done));
    if (ev) begin
      chk("mem_addr", mem_addr, q[0].a);
      chk("mem_wdata", 64'(mem_wdata), 64'(q[0].w));
    end
    s_acc      = req_valid && req_ready;
    s_pop      = mem_valid && mem_ready;
    s_done     = done;
    s_busy     = busy;
    s_pop_addr = mem_addr;
    s_pop_word = mem_wdata;
    if (Reset) begin
      model_reset();
    end else begin
      pop    = ev && mem_ready;
      acc    = req_valid && er;
      m_done = (m_phase == 2) && !ev;
      m_err  = 1'b0;
      if (pop) begin
        q.delete(0);
        m_wc = (m_wc + 1) % 65536;
      end
      if (acc) begin
        simm = longint'($signed(req_imm));
        if (ref_legal(int'(req_op), simm)) begin
          q.push_back('{m_addr, ref_enc(int'(req_op), int'(req_rd), int'(req_rn),
                                        int'(req_rm), simm, int'(req_hw))});
          m_addr = m_addr + 64'd4;
        end else begin
          m_err = 1'b1;
          if (m_errc < 255) m_errc++;
        end
      end
      case (m_phase)
        0: if (start) begin
             m_phase = 1;
             m_addr  = base_addr;
             m_wc    = 0;
             m_errc  = 0;
           end
        1: if (acc && req_last) m_phase = 2;
        2: if (!ev) m_phase = 0;
        default: ;
      endcase
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input int op, input int rd, input int rn, input int rm,
                      input longint imm, input int hw, input bit last);
    req_op    = 4'(op);
    req_rd    = 5'(rd);
    req_rn    = 5'(rn);
    req_rm    = 5'(rm);
    req_imm   = 32'(imm);
    req_hw    = 2'(hw);
    req_last  = last;
    req_valid = 1'b1;
    s_acc     = 1'b0;
    for (int k = 0; k < 50; k++) begin
      cycle();
      if (s_acc) break;
    end
    chk("send_accepted", 64'(s_acc), 64'd1);
    req_valid = 1'b0;
    req_last  = 1'b0;
  endtask

  task automatic wait_pop();
    s_pop = 1'b0;
    for (int k = 0; k < 30; k++) begin
      cycle();
      if (s_pop) break;
    end
    chk("pop_seen", 64'(s_pop), 64'd1);
  endtask

  task automatic begin_prog(input logic [63:0] base);
    base_addr = base;
    start     = 1'b1;
    cycle();
    start     = 1'b0;
  endtask

  task automatic finish_prog();
    mem_ready = 1'b1;
    send(0, 1, 1, 1, 0, 0, 1'b1);
    s_done = 1'b0;
    for (int k = 0; k < 30; k++) begin
      cycle();
      if (s_done) break;
    end
    chk("done_seen", 64'(s_done), 64'd1);
    chk("busy_at_done", 64'(s_busy), 64'd0);
    cycle();
  endtask

  logic [63:0] pa [3];
  int          n;

  initial begin
    Reset = 1'b1; start = 1'b0; base_addr = '0; req_valid = 1'b0; req_op = '0;
    req_rd = '0; req_rn = '0; req_rm = '0; req_imm = '0; req_hw = '0;
    req_last = 1'b0; mem_ready = 1'b0;
    model_reset();
    #1;
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    cycle();
    cycle();
    Reset = 1'b0;
    cycle();

    // Encoding and negative-offset vectors
    begin_prog(64'h100);
    mem_ready = 1'b1;
    send(0, 1, 2, 3, 0, 0, 1'b0);
    wait_pop();
    chk("add_addr", s_pop_addr, 64'h100);
    chk("add_word", 64'(s_pop_word), 64'h8B03_0041);
    send(9, 5, 6, 0, -8, 0, 1'b0);
    wait_pop();
    chk("ldur_addr", s_pop_addr, 64'h104);
    chk("ldur_word", 64'(s_pop_word), 64'hF85F_80C5);
    send(7, 0, 0, 0, -1, 0, 1'b0);
    wait_pop();
    chk("b_word", 64'(s_pop_word), 64'h17FF_FFFF);

    // Rejection leaves no address gap
    send(4, 1, 1, 0, 4096, 0, 1'b0);
    chk("rej_err", 64'(err), 64'd1);
    chk("rej_count", 64'(err_count), 64'd1);
    chk("rej_nowrite", 64'(mem_valid), 64'd0);
    send(4, 7, 8, 0, 4095, 0, 1'b0);
    wait_pop();
    chk("rej_next_addr", s_pop_addr, 64'h10C);

    // Completion
    send(6, 3, 0, 0, 48879, 2, 1'b1);
    chk("drain_ready", 64'(req_ready), 64'd0);
    chk("drain_busy", 64'(busy), 64'd1);
    s_done = 1'b0;
    for (int k = 0; k < 30; k++) begin
      cycle();
      if (s_done) break;
    end
    chk("final_done_seen", 64'(s_done), 64'd1);
    chk("final_busy_low", 64'(s_busy), 64'd0);
    cycle();

    // Back-pressure
    begin_prog(64'h100);
    mem_ready = 1'b0;
    send(0, 1, 2, 3, 0, 0, 1'b0);
    send(1, 4, 5, 6, 0, 0, 1'b0);
    req_op = 4'd3; req_rd = 5'd9; req_rn = 5'd10; req_rm = 5'd11; req_valid = 1'b1;
    cycle();
    cycle();
    chk("bp_ready_low", 64'(req_ready), 64'd0);
    chk("bp_mem_valid", 64'(mem_valid), 64'd1);
    mem_ready = 1'b1;
    n = 0;
    for (int k = 0; k < 30; k++) begin
      cycle();
      if (s_acc) req_valid = 1'b0;
      if (s_pop) begin
        pa[n] = s_pop_addr;
        n++;
      end
      if (n == 3) break;
    end
    chk("bp_pops", 64'(n), 64'd3);
    chk("bp_addr0", pa[0], 64'h100);
    chk("bp_addr1", pa[1], 64'h104);
    chk("bp_addr2", pa[2], 64'h108);
    chk("bp_word_count", 64'(word_count), 64'd3);
    req_valid = 1'b0;
    finish_prog();

    // err_count saturation
    begin_prog(64'h2000);
    req_op = 4'd15; req_valid = 1'b1;
    for (int k = 0; k < 260; k++) cycle();
    req_valid = 1'b0;
    chk("err_sat", 64'(err_count), 64'd255);
    finish_prog();

    // Randomized traffic, one program straddling the address wrap
    for (int p = 0; p < 2; p++) begin
      begin_prog((p == 0) ? 64'hFFFF_FFFF_FFFF_FFF0 : {$urandom, $urandom});
      for (int i = 0; i < 400; i++) begin
        start     = ($urandom % 8 == 0);
        req_op    = 4'($urandom % 16);
        req_rd    = 5'($urandom);
        req_rn    = 5'($urandom);
        req_rm    = 5'($urandom);
        req_hw    = 2'($urandom);
        req_imm   = 32'(pick_imm(int'(req_op)));
        req_valid = ($urandom % 4 != 0);
        mem_ready = ($urandom % 3 != 0);
        cycle();
      end
      start = 1'b0;
      req_valid = 1'b0;
      finish_prog();
    end

    // Reset mid-load with a full FIFO
    begin_prog(64'h300);
    mem_ready = 1'b0;
    send(0, 1, 2, 3, 0, 0, 1'b0);
    send(2, 4, 5, 6, 0, 0, 1'b0);
    cycle();
    chk("pre_rst_valid", 64'(mem_valid), 64'd1);
    Reset = 1'b1;
    #1;
    chk("rst_valid", 64'(mem_valid), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_addr", mem_addr, 64'd0);
    chk("rst_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_wc", 64'(word_count), 64'd0);
    chk("rst_ec", 64'(err_count), 64'd0);
    model_reset();
    cycle();
    Reset = 1'b0;
    mem_ready = 1'b1;
    n = 0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      if (s_pop) n++;
    end
    chk("rst_no_writes", 64'(n), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
